// File: rtl/impl_test_harness.sv
// impl_test_harness
//   Implementation-test wrapper for a wide solver core. An addressed narrow write port loads
//   the core's input bank. A start handshake launches the core. The result bank is captured,
//   the core latency is measured and a hung core is aborted by a timeout. All results are
//   folded through a registered XOR tree into one signature word, so every result bit stays
//   observable and the core cannot be pruned.
//
//   Optional build macro: IMPL_HARNESS_ROTATE_EN
//     Rotates result word k left by (k mod DATA_WIDTH) before the tree, so identical result
//     words no longer cancel. Latency is unchanged.
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     cfg_data/addr/we    input-bank write port (ignored while busy or addr >= NUM_IN)
//     start               run request, level-sampled in IDLE
//     dut_in              registered input bank to the core
//     dut_start           one-cycle launch pulse to the core
//     dut_valid           core result-valid (only observed while waiting)
//     dut_result          core result bank
//     sig_out/sig_valid   folded signature and its one-cycle strobe
//     busy                high in any state other than IDLE
//     timeout             sticky: last run was aborted
//     latency_cnt         wait cycles of the last run (saturating)
module impl_test_harness #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NUM_IN         = 50,
    parameter int unsigned NUM_OUT        = 52,
    parameter int unsigned FOLD           = 5,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_WIDTH-1:0]              cfg_data,
    input  logic [ADDR_WIDTH-1:0]              cfg_addr,
    input  logic                               cfg_we,
    input  logic                               start,
    output logic [NUM_IN-1:0][DATA_WIDTH-1:0]  dut_in,
    output logic                               dut_start,
    input  logic                               dut_valid,
    input  logic [NUM_OUT-1:0][DATA_WIDTH-1:0] dut_result,
    output logic [DATA_WIDTH-1:0]              sig_out,
    output logic                               sig_valid,
    output logic                               busy,
    output logic                               timeout,
    output logic [CNT_WIDTH-1:0]               latency_cnt
);

    // Lanes left after 'stage' tree stages of ceil(n / FOLD) reduction.
    function automatic int unsigned lanes_at(input int unsigned stage);
        int unsigned n;
        n = NUM_OUT;
        for (int unsigned i = 0; i < stage; i++) begin
            n = (n + FOLD - 1) / FOLD;
        end
        return n;
    endfunction

    // Number of registered stages needed to reach a single lane.
    function automatic int unsigned num_stages();
        int unsigned n;
        int unsigned c;
        n = NUM_OUT;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 1) begin
                n = (n + FOLD - 1) / FOLD;
                c++;
            end
        end
        return c;
    endfunction

    localparam int unsigned NumStages = num_stages();

`ifdef IMPL_HARNESS_ROTATE_EN
    function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] w,
                                                    input int unsigned r);
        logic [2*DATA_WIDTH-1:0] dbl;
        dbl = {w, w} << r;
        return dbl[2*DATA_WIDTH-1 -: DATA_WIDTH];
    endfunction
`endif

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StFold, StDone} state_e;

    state_e state_q, state_d;

    // Reset: asserts asynchronously, releases synchronously to clk.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic [NUM_IN-1:0][DATA_WIDTH-1:0] bank_q;
    logic [CNT_WIDTH-1:0]              lat_q;
    logic [CNT_WIDTH-1:0]              lat_inc;
    logic                              timeout_q;
    logic                              at_limit;
    logic [7:0]                        fold_cnt_q;
    logic [DATA_WIDTH-1:0]             sig_q;
    logic                              sig_valid_q;

    // Stage 0 is the capture bank; stages 1..NumStages are the XOR tree.
    logic [DATA_WIDTH-1:0] stage_q [NumStages+1][NUM_OUT];
    logic [DATA_WIDTH-1:0] stage_d [NumStages+1][NUM_OUT];

    assign lat_inc  = (&lat_q) ? lat_q : lat_q + CNT_WIDTH'(1);
    // Limit is judged on the count including the current wait cycle.
    assign at_limit = (lat_inc >= CNT_WIDTH'(TIMEOUT_CYCLES));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StLaunch;
            StLaunch: state_d = StWait;
            StWait: begin
                if (dut_valid || at_limit) begin
                    state_d = (NumStages == 0) ? StDone : StFold;
                end
            end
            StFold:   if (fold_cnt_q == 8'(NumStages - 1)) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state_q != StIdle);
        dut_start = (state_q == StLaunch);
    end

    // ---------------- Input bank ----------------
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            bank_q <= '0;
        end else if (cfg_we && !busy) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (cfg_addr == ADDR_WIDTH'(i)) begin
                    bank_q[i] <= cfg_data;
                end
            end
        end
    end

    // ---------------- Capture bank and XOR tree ----------------
    always_comb begin
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            stage_d[0][j] = stage_q[0][j];
            if (state_q == StWait) begin
                if (dut_valid) begin
`ifdef IMPL_HARNESS_ROTATE_EN
                    stage_d[0][j] = rotl(dut_result[j], j % DATA_WIDTH);
`else
                    stage_d[0][j] = dut_result[j];
`endif
                end else if (at_limit) begin
                    stage_d[0][j] = '0;
                end
            end
        end
        // Tree runs freely; it settles while the capture bank is held through FOLD.
        for (int unsigned s = 1; s <= NumStages; s++) begin
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                stage_d[s][j] = '0;
                if (j < lanes_at(s)) begin
                    for (int unsigned k = 0; k < FOLD; k++) begin
                        // Lanes beyond the previous stage's width act as zero padding.
                        if ((j * FOLD + k) < lanes_at(s - 1)) begin
                            stage_d[s][j] = stage_d[s][j] ^ stage_q[s-1][j*FOLD+k];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int unsigned s = 0; s <= NumStages; s++) begin
                for (int unsigned j = 0; j < NUM_OUT; j++) begin
                    stage_q[s][j] <= '0;
                end
            end
        end else begin
            for (int unsigned s = 0; s <= NumStages; s++) begin
                for (int unsigned j = 0; j < NUM_OUT; j++) begin
                    stage_q[s][j] <= stage_d[s][j];
                end
            end
        end
    end

    // ---------------- Run bookkeeping and signature ----------------
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lat_q       <= '0;
            timeout_q   <= 1'b0;
            fold_cnt_q  <= 8'd0;
            sig_q       <= '0;
            sig_valid_q <= 1'b0;
        end else begin
            sig_valid_q <= (state_q == StDone);
            fold_cnt_q  <= (state_q == StFold) ? fold_cnt_q + 8'd1 : 8'd0;
            if (state_q == StIdle && start) begin
                lat_q     <= '0;
                timeout_q <= 1'b0;
            end
            if (state_q == StWait) begin
                lat_q <= lat_inc;
                if (!dut_valid && at_limit) begin
                    timeout_q <= 1'b1;
                end
            end
            if (state_q == StDone) begin
                sig_q <= stage_q[NumStages][0];
            end
        end
    end

    assign dut_in      = bank_q;
    assign sig_out     = sig_q;
    assign sig_valid   = sig_valid_q;
    assign timeout     = timeout_q;
    assign latency_cnt = lat_q;

endmodule

// File: tb/tb_impl_test_harness.sv
module tb_impl_test_harness;

    localparam int unsigned DW = 64;
    localparam int unsigned NI = 50;
    localparam int unsigned NO = 52;
    localparam int unsigned FO = 5;
    localparam int unsigned AW = 10;
    localparam int unsigned TO = 100;
    localparam int unsigned CW = 32;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [DW-1:0]              cfg_data;
    logic [AW-1:0]              cfg_addr;
    logic                       cfg_we;
    logic                       start;
    logic [NI-1:0][DW-1:0]      dut_in;
    logic                       dut_start;
    logic                       dut_valid;
    logic [NO-1:0][DW-1:0]      dut_result;
    logic [DW-1:0]              sig_out;
    logic                       sig_valid;
    logic                       busy;
    logic                       timeout;
    logic [CW-1:0]              latency_cnt;

    impl_test_harness #(
        .DATA_WIDTH    (DW),
        .NUM_IN        (NI),
        .NUM_OUT       (NO),
        .FOLD          (FO),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_we     (cfg_we),
        .start      (start),
        .dut_in     (dut_in),
        .dut_start  (dut_start),
        .dut_valid  (dut_valid),
        .dut_result (dut_result),
        .sig_out    (sig_out),
        .sig_valid  (sig_valid),
        .busy       (busy),
        .timeout    (timeout),
        .latency_cnt(latency_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] sig;
        logic          to;
        int            lat;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            start_pulses = 0;
    int            runs_issued = 0;
    int            lstages = 0;
    logic [DW-1:0] shadow[NI];
    logic [DW-1:0] core_res[NO];
    int            core_delay = 0;
    bit            core_echo = 1'b0;
    logic [DW-1:0] last_sig = '0;

    function automatic void check(input string name, input logic [DW-1:0] act,
                                  input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic logic [DW-1:0] ref_rotl(input logic [DW-1:0] w, input int k);
        int r;
        r = k % DW;
        if (r == 0) return w;
        return (w << r) | (w >> (DW - r));
    endfunction

    // Signature is simply the XOR of every (optionally rotated) result word.
    function automatic logic [DW-1:0] ref_sig(input logic [DW-1:0] r[NO]);
        logic [DW-1:0] acc;
        acc = '0;
        for (int k = 0; k < NO; k++) begin
`ifdef IMPL_HARNESS_ROTATE_EN
            acc ^= ref_rotl(r[k], k);
`else
            acc ^= r[k];
`endif
        end
        return acc;
    endfunction

    // Core model: answers 'core_delay' wait cycles after the launch pulse (0 = never).
    initial begin
        dut_valid  = 1'b0;
        dut_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dut_start && core_delay > 0) begin
                repeat (core_delay) @(posedge clk);
                @(negedge clk);
                for (int k = 0; k < NO; k++) begin
                    if (core_echo) dut_result[k] = (k < NI) ? dut_in[k] : '0;
                    else           dut_result[k] = core_res[k];
                end
                dut_valid = 1'b1;
                @(posedge clk);
                #1;
                dut_valid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a signature strobe appears.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (dut_start) start_pulses++;
            if (sig_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sig_valid", 64'(sig_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sig_out", sig_out, e.sig);
                    check("timeout", 64'(timeout), 64'(e.to));
                    check("latency_cnt", 64'(latency_cnt), 64'(e.lat));
                    check("sig_cycle", 64'(cyc), 64'(e.cyc));
                    check("busy_at_sig", 64'(busy), 64'd0);
                end
                done_cnt++;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at a negedge.
    task automatic wr(input int addr, input logic [DW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (addr < NI) shadow[addr] = d;
    endtask

    task automatic run(input int delay, input bit echo, input bit wait_res);
        exp_t          e;
        logic [DW-1:0] r[NO];
        int            w;
        int            d0;
        core_delay = delay;
        core_echo  = echo;
        for (int k = 0; k < NO; k++) r[k] = echo ? ((k < NI) ? shadow[k] : '0) : core_res[k];
        e.to = (delay == 0);
        w    = (delay == 0) ? TO : delay;
        e.sig = e.to ? '0 : ref_sig(r);
        e.lat = w;
        // Start presented in cycle c, strobe visible in cycle c + 2 + W + L + 1.
        e.cyc = cyc + 3 + w + lstages;
        d0 = done_cnt;
        if (wait_res) begin
            exp_q.push_back(e);
            last_sig = e.sig;
        end
        runs_issued++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (wait_res) begin
            for (int n = 0; n < 400 && done_cnt == d0; n++) @(negedge clk);
            check("run_completed", 64'(done_cnt != d0), 64'd1);
            @(negedge clk);
            check("sig_valid_one_cycle", 64'(sig_valid), 64'd0);
        end
    endtask

    task automatic check_bank(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < NI; i++) if (dut_in[i] !== shadow[i]) bad++;
        check(name, 64'(bad), 64'd0);
    endtask

    initial begin
        int n;
        n = NO;
        while (n > 1) begin
            n = (n + FO - 1) / FO;
            lstages++;
        end
        for (int i = 0; i < NI; i++) shadow[i] = '0;
        for (int k = 0; k < NO; k++) core_res[k] = '0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sig_out", sig_out, 64'd0);
        check("rst_sig_valid", 64'(sig_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_latency", 64'(latency_cnt), 64'd0);
        check("rst_dut_start", 64'(dut_start), 64'd0);
        check("rst_dut_in", 64'(|dut_in), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed echo run.
        for (int a = 0; a < NI; a++) wr(a, DW'(a + 1));
        wr(50, 64'hFF);
        check("bank_49", dut_in[49], 64'd50);
        check_bank("bank_after_load");
        run(7, 1'b1, 1'b1);
`ifndef IMPL_HARNESS_ROTATE_EN
        check("echo_sig_const", sig_out, 64'h33);
`endif
        check("one_launch", 64'(start_pulses), 64'd1);

        // Identical words.
        for (int k = 0; k < NO; k++) core_res[k] = 64'hDEADBEEF;
        run(12, 1'b0, 1'b1);
`ifndef IMPL_HARNESS_ROTATE_EN
        check("same_words_cancel", sig_out, 64'd0);
`endif

        // Core never answers.
        run(0, 1'b0, 1'b1);
        check("timeout_sticky", 64'(timeout), 64'd1);
        check("timeout_idle", 64'(busy), 64'd0);

        // Valid on the last allowed wait cycle wins.
        for (int k = 0; k < NO; k++) core_res[k] = {$urandom, $urandom};
        run(TO, 1'b0, 1'b1);
        for (int k = 0; k < NO; k++) core_res[k] = {$urandom, $urandom};
        run(TO - 1, 1'b0, 1'b1);

        // Writes and start while busy are ignored.
        for (int k = 0; k < NO; k++) core_res[k] = {$urandom, $urandom};
        fork
            run(30, 1'b0, 1'b1);
            begin
                repeat (5) @(negedge clk);
                cfg_we = 1'b1; start = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    cfg_addr = AW'(i * 16);
                    cfg_data = {$urandom, $urandom};
                    @(negedge clk);
                end
                cfg_we = 1'b0; start = 1'b0;
            end
        join
        check_bank("bank_busy_writes");

        // Stray dut_valid in IDLE.
        dut_result = {NO{64'h1234_5678_9ABC_DEF0}};
        dut_valid = 1'b1;
        @(negedge clk);
        dut_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_valid_busy", 64'(busy), 64'd0);
        check("idle_valid_latency", 64'(latency_cnt), 64'd30);
        check("idle_valid_sig", sig_out, last_sig);

        // Randomized runs.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 6; i++) wr($urandom_range(0, 63), {$urandom, $urandom});
            for (int k = 0; k < NO; k++) core_res[k] = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) for (int k = 1; k < NO; k++) core_res[k] = core_res[0];
            run($urandom_range(1, 60), 1'($urandom_range(0, 1)), 1'b1);
        end
        check_bank("bank_random");

        // Reset in the middle of FOLD.
        for (int k = 0; k < NO; k++) core_res[k] = {$urandom, $urandom};
        run(5, 1'b0, 1'b0);
        n = 0;
        while (!dut_valid && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("fold_valid_seen", 64'(dut_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sig_out", sig_out, 64'd0);
        check("midrst_sig_valid", 64'(sig_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_latency", 64'(latency_cnt), 64'd0);
        check("midrst_dut_in", 64'(|dut_in), 64'd0);
        for (int i = 0; i < NI; i++) shadow[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) wr(i * 7, {$urandom, $urandom});
        run(9, 1'b1, 1'b1);

        check("launch_count", 64'(start_pulses), 64'(runs_issued));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/impl_test_harness.md
Name: impl_test_harness

Overview:
- Reusable implementation-test wrapper placed around a solver core (LBFGS-class) for place-and-route and on-board bring-up.
- Loads the core's wide input bank through a narrow addressed write port and launches the core with a start handshake.
- Captures the core's wide result bank, measures core latency and detects timeouts.
- Folds all results into one DATA_WIDTH signature through a registered, pipelined XOR tree so the core is not pruned.

Parameters:
DATA_WIDTH, 64, width of every data word
NUM_IN, 50, number of input words driven to the core
NUM_OUT, 52, number of result words received from the core
FOLD, 5, XOR fan-in per tree stage (>=2)
ADDR_WIDTH, 10, width of cfg_addr
TIMEOUT_CYCLES, 65535, maximum WAIT cycles before abort
CNT_WIDTH, 32, width of latency_cnt

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_data  input  DATA_WIDTH  input-bank write data
cfg_addr  input  ADDR_WIDTH  input-bank word index
cfg_we  input  1  input-bank write enable
start  input  1  run request, level-sampled
dut_in  output  NUM_IN x DATA_WIDTH  registered input bank to the core
dut_start  output  1  one-cycle launch pulse to the core
dut_valid  input  1  core result-valid
dut_result  input  NUM_OUT x DATA_WIDTH  core results
sig_out  output  DATA_WIDTH  folded signature
sig_valid  output  1  one-cycle signature strobe
busy  output  1  high in any state other than IDLE
timeout  output  1  sticky flag: last run aborted
latency_cnt  output  CNT_WIDTH  WAIT cycles of the last run

Behaviour:
- Reset (async assert, sync deassert internally): FSM=IDLE; dut_in all 0, dut_start 0, sig_out 0, sig_valid 0, busy 0, timeout 0, latency_cnt 0, capture bank and tree registers 0. Reset asserted mid-run aborts immediately with no sig_valid.
- Input bank: when cfg_we=1, busy=0 and cfg_addr<NUM_IN, dut_in[cfg_addr] <= cfg_data on the next edge. Addresses >=NUM_IN are ignored. Writes while busy are ignored, so core inputs stay stable during a run.
- FSM states:
  - IDLE: start=1 -> LAUNCH; clear timeout and latency_cnt.
  - LAUNCH: assert dut_start for exactly 1 cycle -> WAIT.
  - WAIT: latency_cnt increments each cycle, saturating at all-ones.
    - dut_valid=1: capture dut_result into the capture bank -> FOLD.
    - Otherwise, when latency_cnt reaches TIMEOUT_CYCLES: set timeout=1, load zeros into the capture bank -> FOLD.
    - dut_valid on the same cycle as the timeout limit: valid wins, no timeout.
  - FOLD: L cycles, L = number of stages needed to reduce NUM_OUT lanes to 1, with lanes per stage = ceil(n/FOLD). Defaults: 52->11->3->1, L=3. Missing lanes are zero-padded. Each stage is registered. -> DONE.
  - DONE: sig_out <= tree output; sig_valid=1 for 1 cycle -> IDLE.
- sig_out holds its value until the next DONE.
- Total latency: start sampled to sig_valid = 2 + W + L + 1 cycles, where W is the number of WAIT cycles.
- dut_valid is ignored outside WAIT. start is ignored while busy=1.
- NUM_OUT=1 gives L=0, and FOLD passes straight to DONE.

Optional Feature:
- Macro IMPL_HARNESS_ROTATE_EN.
  - Defined: before entering the tree, result word k is rotated left by (k mod DATA_WIDTH) bits. Identical result words therefore no longer cancel in the signature.
  - Undefined: raw XOR of the words; rotate logic is absent and latency is unchanged.

Test Plan:
- Write addrs 0..49 with data=addr+1, addr 50 with 0xFF, then start; core model echoes dut_in as results 0..49 and drives 0 on 50..51 after 7 cycles -> dut_in[49]=50; addr 50 write causes no change; latency_cnt=7; one sig_valid; sig_out = XOR of 1..50 = 0x33 (rotate off).
- All 52 results = 0xDEADBEEF -> sig_out=0 with rotate off; with IMPL_HARNESS_ROTATE_EN, sig_out = XOR of rotl(0xDEADBEEF,k) for k=0..51, computed by the reference model.
- Core never asserts dut_valid, TIMEOUT_CYCLES=100 -> timeout=1, latency_cnt=100, sig_out=0, sig_valid pulses once, busy drops.
- dut_valid arrives on WAIT cycle 100 with TIMEOUT_CYCLES=100 -> timeout=0; results are captured.
- Assert rst_n=0 during FOLD -> all outputs 0 asynchronously; no sig_valid; next start runs normally.
- cfg_we or start asserted while busy -> dut_in unchanged; no second dut_start; dut_valid pulsed in IDLE has no effect.
